pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter N, default 32, SHALL set PC/address width in bits.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 next_pc_in  input  N  SHALL carry the selected next PC from the upstream next-PC 2:1 mux output.
REQ-006 redirect  input  1  SHALL carry the next-PC mux select; 1 means next_pc_in is a branch/jump target.
REQ-007 stall  input  1  SHALL hold the PC when 1.
REQ-008 imem_req  output  1  SHALL request an instruction fetch at imem_addr.
REQ-009 imem_addr  output  N  SHALL equal pc.
REQ-010 imem_ack  input  1  SHALL signal fetch completion for the current request.
REQ-011 pc  output  N  SHALL be the current program counter.
REQ-012 pc_plus4  output  N  SHALL equal pc+4 modulo 2^N; it drives the mux sequential input.
REQ-013 fetch_valid  output  1  SHALL pulse for one cycle per completed, non-aborted fetch.
REQ-014 misalign_err  output  1  SHALL flag a misaligned target load (sticky).
REQ-015 fetch_count  output  32  SHALL report completed fetches (see Configuration).

Function
REQ-016 FSM states SHALL be REQ, HOLD, ERR; reset state is REQ.
REQ-017 In REQ, imem_req SHALL be 1; in HOLD and ERR, 0.
REQ-018 REQ, imem_ack=1, stall=0: pc <= next_pc_in, fetch_valid=1 next cycle, stay REQ.
REQ-019 REQ, imem_ack=1, stall=1: pc held, fetch_valid=1 next cycle, go HOLD.
REQ-020 HOLD, stall=0: pc <= next_pc_in, go REQ; HOLD, stall=1: stay HOLD, pc held.
REQ-021 REQ, redirect=1, imem_ack=0, stall=0: abort, pc <= next_pc_in, stay REQ, no fetch_valid.
REQ-022 redirect=1 with imem_ack=1 in the same cycle SHALL follow REQ-018/019 (fetch completes, target loaded).
REQ-023 Any load with next_pc_in[1:0]!=0 SHALL NOT update pc; go ERR; set misalign_err=1.
REQ-024 ERR SHALL be left only via reset; pc frozen, fetch_valid 0.
REQ-025 imem_ack outside REQ SHALL be ignored.
REQ-026 pc_plus4 SHALL wrap: pc=2^N-4 gives pc_plus4=0.
REQ-027 Latency: ack-to-pc-update exactly 1 clock; no combinational path imem_ack->imem_req.

Reset
REQ-028 On rst_n=0, immediately: pc=RESET_PC, state REQ, fetch_valid=0, misalign_err=0, fetch_count=0; imem_req becomes 1 while in REQ.
REQ-029 Reset mid-fetch SHALL abandon the outstanding request; the first post-reset request SHALL use address RESET_PC.

Configuration
REQ-030 Macro PC_FETCH_PERF_CNT_EN defined: fetch_count increments by 1 on each fetch_valid pulse, wraps 0xFFFFFFFF->0.
REQ-031 Macro undefined: fetch_count tied to 0, no counter flops synthesized; all other behaviour identical.

Structure
REQ-032 Package pc_fetch_pkg SHALL hold the FSM state encoding and the instruction-size constant (4).
REQ-033 Sub-module pc_adder (N-bit +4 incrementer) SHALL produce pc_plus4.

Verification
REQ-034 Reset, RESET_PC=0x100, ack every cycle, next_pc_in=pc_plus4 -> pc 0x100,0x104,0x108; fetch_valid=1 each cycle.
REQ-035 Ack with stall=1 for 3 cycles -> one fetch_valid pulse, imem_req=0 for 3 cycles, pc held, then load.
REQ-036 redirect=1, next_pc_in=0x200, imem_ack=0 -> pc=0x200 next cycle, no fetch_valid.
REQ-037 next_pc_in=0x202 loaded -> misalign_err=1, imem_req=0, pc unchanged until rst_n pulse.
REQ-038 pc=0xFFFFFFFC -> pc_plus4=0; with PC_FETCH_PERF_CNT_EN, 5 fetches -> fetch_count=5; without it, 0.
REQ-039 rst_n low during REQ wait -> pc=RESET_PC immediately, misalign_err=0, fetch_count=0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: FSM state encoding and instruction-size constant for pc_fetch_unit.
package pc_fetch_pkg;
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_ERR} state_t;
    localparam int INSN_BYTES = 4;
endpackage

// File: rtl/pc_adder.sv
// pc_adder: N-bit incrementer producing pc + INSN_BYTES, wrapping modulo 2^N.
module pc_adder import pc_fetch_pkg::*; #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] sum
);
    assign sum = a + N'(INSN_BYTES);
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and fetch handshake FSM; define PC_FETCH_PERF_CNT_EN to enable fetch_count.
module pc_fetch_unit import pc_fetch_pkg::*; #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] next_pc_in,
    input  logic         redirect,
    input  logic         stall,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         fetch_valid,
    output logic         misalign_err,
    output logic [31:0]  fetch_count
);
    state_t state;
    logic complete, load, bad_load, fv_next;

    always_comb begin
        complete = state == S_REQ && imem_ack;
        load     = !stall && ((state == S_REQ && (imem_ack || redirect)) || state == S_HOLD);
        bad_load = load && next_pc_in[1:0] != 2'b00;
        fv_next  = complete && !bad_load;
    end

    assign imem_req  = state == S_REQ;
    assign imem_addr = pc;

    pc_adder #(.N(N)) u_adder (.a(pc), .sum(pc_plus4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            fetch_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            fetch_valid <= fv_next;
            if (bad_load) begin
                state        <= S_ERR;
                misalign_err <= 1'b1;
            end else if (load) begin
                state <= S_REQ;
                pc    <= next_pc_in;
            end else if (complete) begin
                state <= S_HOLD;
            end
        end
    end

`ifdef PC_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_count <= '0;
        else if (fv_next) fetch_count <= fetch_count + 32'd1;
    end
`else
    assign fetch_count = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table plus hand sequences for reset, wrap and counter.
module tb_pc_fetch_unit;
    localparam logic [31:0] RPC = 32'h100;
`ifdef PC_FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 0, rst_n = 0, redirect = 0, stall = 0, imem_ack = 0;
    logic [31:0] next_pc_in = '0;
    logic        imem_req, fetch_valid, misalign_err;
    logic [31:0] imem_addr, pc, pc_plus4, fetch_count;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.N(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .next_pc_in(next_pc_in), .redirect(redirect),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    typedef struct {
        logic        rd, st, ack;
        logic [31:0] nxt, e_pc;
        logic        e_req, e_fv, e_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_req,
                             input logic e_fv, input logic e_err);
        check({tag, " pc"}, pc, e_pc);
        check({tag, " addr"}, imem_addr, e_pc);
        check({tag, " plus4"}, pc_plus4, e_pc + 32'd4);
        check({tag, " req"}, {31'd0, imem_req}, {31'd0, e_req});
        check({tag, " fv"}, {31'd0, fetch_valid}, {31'd0, e_fv});
        check({tag, " err"}, {31'd0, misalign_err}, {31'd0, e_err});
    endtask

    task automatic step(input logic rd, input logic st, input logic ack, input logic [31:0] nxt);
        @(negedge clk);
        redirect = rd; stall = st; imem_ack = ack; next_pc_in = nxt;
        @(posedge clk);
        #1;
    endtask

    vec_t v[14];

    initial begin
        v[0]  = '{0, 0, 1, 32'h104, 32'h104, 1, 1, 0};
        v[1]  = '{0, 0, 1, 32'h108, 32'h108, 1, 1, 0};
        v[2]  = '{0, 0, 1, 32'h10C, 32'h10C, 1, 1, 0};
        v[3]  = '{0, 1, 1, 32'h110, 32'h10C, 0, 1, 0};
        v[4]  = '{0, 1, 1, 32'h110, 32'h10C, 0, 0, 0};
        v[5]  = '{0, 1, 0, 32'h110, 32'h10C, 0, 0, 0};
        v[6]  = '{0, 0, 0, 32'h110, 32'h110, 1, 0, 0};
        v[7]  = '{0, 0, 0, 32'h200, 32'h110, 1, 0, 0};
        v[8]  = '{1, 0, 0, 32'h200, 32'h200, 1, 0, 0};
        v[9]  = '{1, 0, 1, 32'h300, 32'h300, 1, 1, 0};
        v[10] = '{1, 1, 0, 32'h400, 32'h300, 1, 0, 0};
        v[11] = '{1, 0, 0, 32'h202, 32'h300, 0, 0, 1};
        v[12] = '{0, 0, 1, 32'h304, 32'h300, 0, 0, 1};
        v[13] = '{1, 0, 0, 32'h400, 32'h300, 0, 0, 1};

        repeat (2) @(negedge clk);
        check_all("reset", RPC, 1, 0, 0);
        check("reset cnt", fetch_count, 32'd0);
        rst_n = 1;

        foreach (v[i]) begin
            step(v[i].rd, v[i].st, v[i].ack, v[i].nxt);
            check_all($sformatf("vec%0d", i), v[i].e_pc, v[i].e_req, v[i].e_fv, v[i].e_err);
        end

        // asynchronous reset clears the sticky error without waiting for a clock edge
        @(negedge clk);
        imem_ack = 0; redirect = 0; stall = 0;
        #2 rst_n = 0;
        #1 check_all("async rst err", RPC, 1, 0, 0);
        @(negedge clk) rst_n = 1;

        step(1, 0, 0, 32'h500);
        check_all("redir 500", 32'h500, 1, 0, 0);
        @(negedge clk);
        redirect = 0;
        #2 rst_n = 0;
        #1 check_all("rst mid fetch", RPC, 1, 0, 0);
        check("rst mid cnt", fetch_count, 32'd0);
        @(negedge clk) rst_n = 1;
        step(0, 0, 0, 32'h0);
        check_all("post rst req", RPC, 1, 0, 0);

        step(1, 0, 0, 32'hFFFF_FFFC);
        check("wrap pc", pc, 32'hFFFF_FFFC);
        check("wrap plus4", pc_plus4, 32'h0);
        step(0, 0, 1, 32'h0);
        check_all("wrap load", 32'h0, 1, 1, 0);

        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
        for (int k = 1; k <= 5; k++) step(0, 0, 1, RPC + 32'(4 * k));
        check_all("cnt run", RPC + 32'd20, 1, 1, 0);
        check("fetch_count", fetch_count, PERF ? 32'd5 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
